// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the MEM stage: bus widths, EX status codes, load/store
// opcodes, FSM states and the load-extension helpers.
package mem_access_stage_pkg;

  localparam int REGBUS      = 32;
  localparam int REGADDRBUS  = 5;
  localparam int INSTADDRBUS = 32;

  localparam logic              RST_ENABLE = 1'b0;
  localparam logic [REGBUS-1:0] ZEROWORD   = '0;

  typedef enum logic [2:0] {
    ST_BUBBLE = 3'b000,
    ST_REG    = 3'b001,
    ST_STORE  = 3'b010,
    ST_LOAD   = 3'b011,
    ST_BRANCH = 3'b100,
    ST_JAL    = 3'b101
  } ex_status_e;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACCESS  = 2'd1,
    S_LOAD_WB = 2'd2
  } state_e;

  function automatic logic [2:0] op_nbytes(input logic [5:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: op_nbytes = 3'd1;
      OP_LH, OP_LHU, OP_SH: op_nbytes = 3'd2;
      default:              op_nbytes = 3'd4;
    endcase
  endfunction

  function automatic logic [REGBUS-1:0] load_extend(input logic [5:0] op,
                                                    input logic [REGBUS-1:0] raw);
    case (op)
      OP_LB:   load_extend = {{24{raw[7]}}, raw[7:0]};
      OP_LBU:  load_extend = {24'd0, raw[7:0]};
      OP_LH:   load_extend = {{16{raw[15]}}, raw[15:0]};
      OP_LHU:  load_extend = {16'd0, raw[15:0]};
      default: load_extend = raw;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_stage_ls_byte_sequencer.sv
// Byte-serial load/store sequencer: owns the byte index, byte count, the
// grant/rdata handshake and the little-endian load assembly buffer.
module ls_byte_sequencer
  import mem_access_stage_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   is_store,
  input  logic [2:0]             n_bytes,
  input  logic [INSTADDRBUS-1:0] addr_in,
  input  logic [REGBUS-1:0]      data_in,
  input  logic                   mem_gnt,
  input  logic [7:0]             mem_rdata,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [INSTADDRBUS-1:0] mem_addr,
  output logic [7:0]             mem_wdata,
  output logic                   done,
  output logic [REGBUS-1:0]      load_word
);

  logic [2:0]             k_q, k_d;
  logic [2:0]             n_q, n_d;
  logic [INSTADDRBUS-1:0] addr_q, addr_d;
  logic [REGBUS-1:0]      data_q, data_d;
  logic                   store_q, store_d;
  logic                   pend_q, pend_d;
  logic [1:0]             pidx_q, pidx_d;
  logic [REGBUS-1:0]      buf_q, buf_d;
  logic [2:0]             last_idx;

  assign mem_req   = (k_q != n_q);
  assign mem_we    = mem_req & store_q;
  assign mem_addr  = mem_req ? addr_q + {{(INSTADDRBUS-3){1'b0}}, k_q} : '0;
  assign mem_wdata = mem_req ? data_q[{k_q[1:0], 3'b000} +: 8] : 8'h00;
  assign last_idx  = n_q - 3'd1;

  // Stores finish on the last grant; loads finish when the last byte lands.
  assign done = store_q ? (mem_req && mem_gnt && (k_q == last_idx))
                        : (pend_q && ({1'b0, pidx_q} == last_idx));

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign load_word[8*gi +: 8] = (pend_q && (pidx_q == 2'(gi))) ? mem_rdata
                                                                   : buf_q[8*gi +: 8];
  end

  always_comb begin
    k_d     = k_q;
    n_d     = n_q;
    addr_d  = addr_q;
    data_d  = data_q;
    store_d = store_q;
    pend_d  = 1'b0;
    pidx_d  = pidx_q;
    buf_d   = pend_q ? load_word : buf_q;
    if (start) begin
      k_d     = 3'd0;
      n_d     = n_bytes;
      addr_d  = addr_in;
      data_d  = data_in;
      store_d = is_store;
      buf_d   = ZEROWORD;
    end else if (mem_req && mem_gnt) begin
      k_d    = k_q + 3'd1;
      pend_d = ~store_q;
      pidx_d = k_q[1:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      k_q     <= 3'd0;
      n_q     <= 3'd0;
      addr_q  <= '0;
      data_q  <= ZEROWORD;
      store_q <= 1'b0;
      pend_q  <= 1'b0;
      pidx_q  <= 2'd0;
      buf_q   <= ZEROWORD;
    end else begin
      k_q     <= k_d;
      n_q     <= n_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      store_q <= store_d;
      pend_q  <= pend_d;
      pidx_q  <= pidx_d;
      buf_q   <= buf_d;
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// Pipeline MEM stage: registered pass-through of ALU results plus byte-serial
// loads/stores. Define MEM_FWD_EN to drive the fwd_* bypass ports from write-back.
module mem_access_stage
  import mem_access_stage_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [2:0]             ex_status,
  input  logic [5:0]             ex_op,
  input  logic [INSTADDRBUS-1:0] ex_mem_addr,
  input  logic [REGBUS-1:0]      ex_data,
  input  logic [REGADDRBUS-1:0]  ex_rd,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [INSTADDRBUS-1:0] mem_addr,
  output logic [7:0]             mem_wdata,
  input  logic                   mem_gnt,
  input  logic [7:0]             mem_rdata,
  output logic                   stall_req,
  output logic                   wb_valid,
  output logic [REGADDRBUS-1:0]  wb_rd,
  output logic [REGBUS-1:0]      wb_data,
  output logic                   fwd_valid,
  output logic [REGADDRBUS-1:0]  fwd_rd,
  output logic [REGBUS-1:0]      fwd_data
);

  state_e                  state_q, state_d;
  logic [5:0]              op_q, op_d;
  logic [REGADDRBUS-1:0]   rd_q, rd_d;
  logic                    store_q, store_d;
  logic                    wb_valid_q, wb_valid_d;
  logic [REGADDRBUS-1:0]   wb_rd_q, wb_rd_d;
  logic [REGBUS-1:0]       wb_data_q, wb_data_d;
  logic                    is_mem, is_wr, start, seq_done;
  logic [REGBUS-1:0]       load_word;

  assign is_mem = (ex_status == ST_STORE) || (ex_status == ST_LOAD);
  assign is_wr  = (ex_status == ST_REG) || (ex_status == ST_JAL);
  // LOAD_WB accepts a new instruction just like IDLE.
  assign start  = (state_q != S_ACCESS) && is_mem;

  assign stall_req = ((state_q == S_IDLE) && is_mem) || (state_q == S_ACCESS);

  ls_byte_sequencer u_seq (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .is_store  (ex_status == ST_STORE),
    .n_bytes   (op_nbytes(ex_op)),
    .addr_in   (ex_mem_addr),
    .data_in   (ex_data),
    .mem_gnt   (mem_gnt),
    .mem_rdata (mem_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .done      (seq_done),
    .load_word (load_word)
  );

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    rd_d       = rd_q;
    store_d    = store_q;
    wb_valid_d = 1'b0;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    case (state_q)
      S_ACCESS: begin
        if (seq_done) begin
          if (store_q) begin
            state_d = S_IDLE;
          end else begin
            state_d    = S_LOAD_WB;
            wb_valid_d = (rd_q != '0);
            wb_rd_d    = rd_q;
            wb_data_d  = load_extend(op_q, load_word);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        if (is_wr) begin
          wb_valid_d = (ex_rd != '0);
          wb_rd_d    = ex_rd;
          wb_data_d  = ex_data;
        end else if (is_mem) begin
          state_d = S_ACCESS;
          op_d    = ex_op;
          rd_d    = ex_rd;
          store_d = (ex_status == ST_STORE);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      state_q    <= S_IDLE;
      op_q       <= 6'd0;
      rd_q       <= '0;
      store_q    <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= ZEROWORD;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      rd_q       <= rd_d;
      store_q    <= store_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
    end
  end

  assign wb_valid = wb_valid_q;
  assign wb_rd    = wb_rd_q;
  assign wb_data  = wb_data_q;

`ifdef MEM_FWD_EN
  assign fwd_valid = wb_valid_q;
  assign fwd_rd    = wb_rd_q;
  assign fwd_data  = wb_data_q;
`else
  assign fwd_valid = 1'b0;
  assign fwd_rd    = '0;
  assign fwd_data  = ZEROWORD;
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: a cycle-planning model derives expected
// outputs from the timing rules; a byte-wide memory answers the request port.
module tb_mem_access_stage;

  localparam int NCYC = 68;
  localparam logic [5:0] LB = 6'h20, LH = 6'h21, LW = 6'h23, LBU = 6'h24, LHU = 6'h25;
  localparam logic [5:0] SB = 6'h28, SH = 6'h29, SW = 6'h2B;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  ex_status;
  logic [5:0]  ex_op;
  logic [31:0] ex_mem_addr, ex_data;
  logic [4:0]  ex_rd;
  logic        mem_req, mem_we, mem_gnt;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        stall_req, wb_valid, fwd_valid;
  logic [4:0]  wb_rd, fwd_rd;
  logic [31:0] wb_data, fwd_data;

  mem_access_stage dut (
    .clk(clk), .rst(rst), .ex_status(ex_status), .ex_op(ex_op),
    .ex_mem_addr(ex_mem_addr), .ex_data(ex_data), .ex_rd(ex_rd),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rdata(mem_rdata), .stall_req(stall_req),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
  );

  always #5 clk = ~clk;

  // Per-cycle drive schedule
  logic [2:0]  d_status [NCYC];
  logic [5:0]  d_op     [NCYC];
  logic [31:0] d_addr   [NCYC];
  logic [31:0] d_data   [NCYC];
  logic [4:0]  d_rd     [NCYC];
  bit          d_gnt    [NCYC];
  bit          d_rst    [NCYC];
  // Per-cycle expectations
  bit          e_rst    [NCYC];
  bit          e_req    [NCYC];
  bit          e_we     [NCYC];
  logic [31:0] e_addr   [NCYC];
  logic [7:0]  e_wd     [NCYC];
  bit          e_stall  [NCYC];
  bit          e_wbv    [NCYC];
  logic [4:0]  e_rd     [NCYC];
  logic [31:0] e_wbd    [NCYC];

  logic [7:0]  mdl_mem [1024];
  logic [7:0]  dev_mem [1024];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %h expected %h", name, c, act, exp);
    end
  endtask

  function automatic int nbytes(input logic [5:0] op);
    if (op == LB || op == LBU || op == SB) return 1;
    if (op == LH || op == LHU || op == SH) return 2;
    return 4;
  endfunction

  task automatic plan_pass(input int t, input logic [2:0] st, input logic [4:0] rd, input logic [31:0] data);
    d_status[t] = st; d_rd[t] = rd; d_data[t] = data; d_op[t] = 6'h00; d_addr[t] = 32'h0;
    if ((st == 3'b001 || st == 3'b101) && rd != 5'd0) begin
      e_wbv[t+1] = 1'b1; e_rd[t+1] = rd; e_wbd[t+1] = data;
    end
  endtask

  // Walks the byte sequence against the grant schedule; cut = cycle a reset hits.
  task automatic plan_mem(input int t, input logic [5:0] op, input logic [31:0] addr,
                          input logic [31:0] data, input logic [4:0] rd, input int cut);
    bit          store;
    int          n, c, g;
    logic [31:0] a, word, ext;
    store = (op == SB || op == SH || op == SW);
    n = nbytes(op);
    d_status[t] = store ? 3'b010 : 3'b011;
    d_op[t] = op; d_addr[t] = addr; d_data[t] = data; d_rd[t] = rd;
    e_stall[t] = 1'b1;
    c = t + 1;
    word = 32'h0;
    for (int k = 0; k < n; k++) begin
      a = addr + k;
      while (c < cut) begin
        e_req[c] = 1'b1; e_we[c] = store; e_addr[c] = a; e_wd[c] = data[8*k +: 8];
        e_stall[c] = 1'b1;
        if (d_gnt[c]) break;
        c++;
      end
      if (c >= cut) return;
      if (store) mdl_mem[a[9:0]] = data[8*k +: 8];
      else       word[8*k +: 8] = mdl_mem[a[9:0]];
      c++;
    end
    g = c - 1;
    if (!store) begin
      e_stall[g+1] = 1'b1;
      case (op)
        LB:      ext = 32'($signed(word[7:0]));
        LH:      ext = 32'($signed(word[15:0]));
        LBU:     ext = word & 32'h0000_00FF;
        LHU:     ext = word & 32'h0000_FFFF;
        default: ext = word;
      endcase
      if (rd != 5'd0) begin
        e_wbv[g+2] = 1'b1; e_rd[g+2] = rd; e_wbd[g+2] = ext;
      end
    end
  endtask

  task automatic plan_reset(input int c0, input int c1);
    for (int c = c0; c <= c1; c++) begin
      d_rst[c] = 1'b1; e_rst[c] = 1'b1;
      e_req[c] = 1'b0; e_stall[c] = 1'b0; e_wbv[c] = 1'b0;
    end
  endtask

  task automatic compare(input int c);
    if (e_rst[c]) begin
      chk("rst_outs", c, {29'd0, mem_req, mem_we, stall_req}, 32'h0);
      chk("rst_addr", c, mem_addr, 32'h0);
      chk("rst_wdata", c, {24'd0, mem_wdata}, 32'h0);
      chk("rst_wb", c, {26'd0, wb_valid, wb_rd}, 32'h0);
      chk("rst_wbdata", c, wb_data, 32'h0);
    end else begin
      chk("mem_req", c, {31'd0, mem_req}, {31'd0, e_req[c]});
      if (e_req[c]) begin
        chk("mem_addr", c, mem_addr, e_addr[c]);
        chk("mem_we", c, {31'd0, mem_we}, {31'd0, e_we[c]});
        if (e_we[c]) chk("mem_wdata", c, {24'd0, mem_wdata}, {24'd0, e_wd[c]});
      end
      chk("stall_req", c, {31'd0, stall_req}, {31'd0, e_stall[c]});
      chk("wb_valid", c, {31'd0, wb_valid}, {31'd0, e_wbv[c]});
      if (e_wbv[c]) begin
        chk("wb_rd", c, {27'd0, wb_rd}, {27'd0, e_rd[c]});
        chk("wb_data", c, wb_data, e_wbd[c]);
      end
    end
`ifdef MEM_FWD_EN
    chk("fwd", c, {26'd0, fwd_valid, fwd_rd}, {26'd0, wb_valid, wb_rd});
    chk("fwd_data", c, fwd_data, wb_data);
`else
    chk("fwd", c, {26'd0, fwd_valid, fwd_rd}, 32'h0);
    chk("fwd_data", c, fwd_data, 32'h0);
`endif
  endtask

  bit       rd_pend;
  logic [9:0] rd_a;

  initial begin
    rst = 1'b0; ex_status = 3'b000; ex_op = 6'h0; ex_mem_addr = 32'h0; ex_data = 32'h0;
    ex_rd = 5'd0; mem_gnt = 1'b0; mem_rdata = 8'h00; rd_pend = 1'b0; rd_a = 10'd0;
    for (int i = 0; i < 1024; i++) begin mdl_mem[i] = 8'h00; dev_mem[i] = 8'h00; end
    mdl_mem[7] = 8'h80; mdl_mem[3] = 8'h34; mdl_mem[4] = 8'h92;
    dev_mem[7] = 8'h80; dev_mem[3] = 8'h34; dev_mem[4] = 8'h92;
    for (int c = 0; c < NCYC; c++) begin
      d_status[c] = 3'b000; d_op[c] = 6'h0; d_addr[c] = 32'h0; d_data[c] = 32'h0;
      d_rd[c] = 5'd0; d_gnt[c] = 1'b1; d_rst[c] = 1'b0;
      e_rst[c] = 1'b0; e_req[c] = 1'b0; e_we[c] = 1'b0; e_addr[c] = 32'h0; e_wd[c] = 8'h0;
      e_stall[c] = 1'b0; e_wbv[c] = 1'b0; e_rd[c] = 5'd0; e_wbd[c] = 32'h0;
    end

    plan_reset(0, 1);
    plan_pass(3, 3'b001, 5'd5, 32'h0000_1234);
    plan_pass(5, 3'b101, 5'd0, 32'h0000_DEAD);
    plan_pass(6, 3'b100, 5'd4, 32'h0000_BEEF);
    plan_pass(7, 3'b101, 5'd31, 32'h0000_0040);
    plan_mem(8, SW, 32'h0000_0100, 32'hAABB_CCDD, 5'd1, 1000);
    plan_mem(14, LB, 32'h0000_0007, 32'h0, 5'd2, 1000);
    plan_mem(19, LBU, 32'h0000_0007, 32'h0, 5'd2, 1000);
    d_gnt[25] = 1'b0;
    plan_mem(23, LH, 32'h0000_0003, 32'h0, 5'd10, 1000);
    plan_mem(30, LW, 32'h0000_0100, 32'h0, 5'd0, 1000);
    plan_mem(37, LW, 32'h0000_0100, 32'h0, 5'd9, 1000);
    plan_mem(45, SH, 32'hFFFF_FFFF, 32'h0000_5A6B, 5'd1, 1000);
    plan_mem(49, LHU, 32'hFFFF_FFFF, 32'h0, 5'd12, 1000);
    plan_pass(53, 3'b001, 5'd7, 32'h0000_0055);
    plan_mem(56, SW, 32'h0000_0200, 32'h1122_3344, 5'd1, 58);
    plan_reset(58, 58);
    plan_mem(60, LB, 32'h0000_0200, 32'h0, 5'd3, 1000);

    // Hand-computed values pin the model itself
    chk("pin_lb", 17, e_wbd[17], 32'hFFFF_FF80);
    chk("pin_lbu", 22, e_wbd[22], 32'h0000_0080);
    chk("pin_lh", 28, e_wbd[28], 32'hFFFF_9234);
    chk("pin_lw", 43, e_wbd[43], 32'hAABB_CCDD);
    chk("pin_lhu", 53, e_wbd[53], 32'h0000_5A6B);
    chk("pin_wrap", 47, e_addr[47], 32'h0000_0000);
    chk("pin_rd0", 36, {31'd0, e_wbv[36]}, 32'h0);

    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk); #1;
      rst         = ~d_rst[c];
      ex_status   = d_status[c];
      ex_op       = d_op[c];
      ex_mem_addr = d_addr[c];
      ex_data     = d_data[c];
      ex_rd       = d_rd[c];
      mem_gnt     = d_gnt[c];
      mem_rdata   = rd_pend ? dev_mem[rd_a] : 8'h00;
      rd_pend     = 1'b0;
      @(negedge clk);
      compare(c);
      if (wb_valid) $display("cyc %0d wb rd=%0d data=%h", c, wb_rd, wb_data);
      if (mem_req && mem_gnt) begin
        if (mem_we) begin
          dev_mem[mem_addr[9:0]] = mem_wdata;
          $display("cyc %0d mem write addr=%h byte=%h", c, mem_addr, mem_wdata);
        end else begin
          rd_pend = 1'b1;
          rd_a    = mem_addr[9:0];
          $display("cyc %0d mem read addr=%h", c, mem_addr);
        end
      end
    end

    chk("mem_100", NCYC, {24'd0, dev_mem[10'h100]}, 32'h0000_00DD);
    chk("mem_103", NCYC, {24'd0, dev_mem[10'h103]}, 32'h0000_00AA);
    chk("mem_wrap_hi", NCYC, {24'd0, dev_mem[10'h3FF]}, 32'h0000_006B);
    chk("mem_wrap_lo", NCYC, {24'd0, dev_mem[10'h000]}, 32'h0000_005A);
    chk("mem_200", NCYC, {24'd0, dev_mem[10'h200]}, 32'h0000_0044);
    chk("mem_201", NCYC, {24'd0, dev_mem[10'h201]}, 32'h0000_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Pipeline MEM stage: consumes the EX result bundle (status, op, address, data, destination register) and performs loads and stores over the byte-wide memory arbiter port. Results go to write-back. Multi-byte accesses are sequenced one byte per granted cycle (little-endian). The stage stalls the upstream pipeline while an access is in flight. Non-memory results pass through with one register stage.

## Interface
- No parameters; widths come from the shared defines (`regbus` = 32, `regaddrbus` = 5, `InstAddrBus` = 32).
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `ex_status`  in  3  001 reg write, 010 store, 011 load, 100 branch, 101 jal/jalr, 000 bubble
- `ex_op`  in  6  opcode (LB/LH/LW/LBU/LHU/SB/SH/SW meaningful)
- `ex_mem_addr`  in  32  effective address
- `ex_data`  in  32  ALU result (reg/jal) or store data
- `ex_rd`  in  5  destination register
- `mem_req`  out  1  byte request valid
- `mem_we`  out  1  1 = write
- `mem_addr`  out  32  byte address
- `mem_wdata`  out  8  write byte
- `mem_gnt`  in  1  request accepted this cycle
- `mem_rdata`  in  8  read byte, valid the cycle after a granted read
- `stall_req`  out  1  to pipeline control; freezes EX/MEM input
- `wb_valid`  out  1  write-back strobe
- `wb_rd`  out  5  write-back register
- `wb_data`  out  32  write-back value
- `fwd_valid`, `fwd_rd`, `fwd_data`  out  1/5/32  forwarding to ID (see Configuration)

## Operation
- FSM states: IDLE, ACCESS, LOAD_WB.
- IDLE with status 001 or 101: register `wb_valid`=1 (if `ex_rd`≠0), `wb_rd`, `wb_data`=`ex_data` on the next edge. Status 000/100: `wb_valid`=0.
- IDLE with status 010/011: latch op, addr, data, rd. Set byte count N (1 for B/BU, 2 for H/HU, 4 for W). Clear byte index k. Go to ACCESS.
- ACCESS: `mem_req`=1, `mem_addr`=addr+k, `mem_we`=store, `mem_wdata`=data[8k+7:8k]. On `mem_gnt`, k increments. Without a grant, outputs hold.
- Loads: the byte returned the cycle after grant k is written into `buf[8k+7:8k]`. After the last grant, `mem_req` drops. The final byte's arrival moves the FSM to LOAD_WB.
- Stores: the last grant returns the FSM to IDLE.
- LOAD_WB: `wb_valid`=1 (if rd≠0) for one cycle, `wb_data` extended per op. LB/LH sign-extend from bit 7/15. LBU/LHU zero-extend. LW uses all 32 bits. Then go to IDLE.
- Misaligned addresses are legal (byte-serial). Address arithmetic wraps mod 2^32.
- `stall_req` = (IDLE and status ∈ {010,011}) or ACCESS.
- `stall_req` is low in LOAD_WB, so the next instruction is accepted while write-back fires.
- `wb_valid` is never asserted for rd=0.

## Timing
- Reset (async, `rst`=0): state IDLE, k=0. `mem_req`, `mem_we`, `stall_req`, `wb_valid`, `fwd_valid` = 0. `mem_addr`, `mem_wdata`, `wb_rd`, `wb_data`, `fwd_rd`, `fwd_data`, buf = 0.
- Reset mid-access abandons the sequence. Bytes already written stay written.
- Pass-through latency: 1 cycle.
- Load, continuous grant, presented in cycle 0: requests in cycles 1..N, data in 2..N+1, `wb_valid` in N+2, stall in cycles 0..N+1.
- Store, continuous grant: requests in cycles 1..N, IDLE in cycle N+1, stall in cycles 0..N.
- Each grant gap adds exactly one cycle.

## Configuration
- `MEM_FWD_EN` defined: `fwd_valid`/`fwd_rd`/`fwd_data` mirror `wb_valid`/`wb_rd`/`wb_data` combinationally, so ID can bypass a load result in its LOAD_WB cycle.
- `MEM_FWD_EN` undefined: forwarding ports are tied to 0.

## Structure
- Shared defines: status codes (001/010/011/100/101), the op codes, bus widths, `rst_enable`, `zeroword`.
- One sub-module, `ls_byte_sequencer`. It owns k, N, the grant/rdata handshake, and buf, and reports `done` to the FSM.

## Test plan
- ADD result status 001, rd=5, data 0x1234 → cycle 1: `wb_valid`=1, `wb_rd`=5, `wb_data`=0x1234, `stall_req`=0 throughout.
- SW addr 0x100, data 0xAABBCCDD, gnt=1 → writes DD,CC,BB,AA to 0x100..0x103 in cycles 1–4. `wb_valid` never set. `stall_req` high in cycles 0–4.
- LB addr 0x7, `mem_rdata` 0x80 → `wb_data`=0xFFFFFF80. The same with LBU → 0x00000080. `wb_valid` in cycle 3.
- LH addr 0x3 (misaligned) with gnt low in cycle 2 → requests to 0x3 and 0x4. Bytes 0x34, 0x92 give `wb_data`=0xFFFF9234 in cycle 5.
- LW to rd=0 → full 4-byte sequence completes and `wb_valid` stays 0.
- Assert `rst`=0 in cycle 2 of an SW → all outputs return to reset values immediately. The next instruction starts cleanly from IDLE.
